// File: rtl/fp_button_regs.sv
// fp_button_regs: keypad matrix scanner with per-key debounce, event FIFO and four-register file.
// Define FP_BUTTON_RELEASE_EVT_EN to queue key releases as well as presses.
module fp_button_regs #(
    parameter int ROWS       = 4,
    parameter int COLS       = 8,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      i_rreg,
    input  logic            i_rd,
    output logic [31:0]     o_rdata,
    input  logic [1:0]      i_wreg,
    input  logic [31:0]     i_wdata,
    input  logic            i_wr,
    output logic [COLS-1:0] o_col,
    input  logic [ROWS-1:0] i_row,
    output logic            o_irq
);
    localparam int NK  = ROWS * COLS;
    localparam int CW  = $clog2(DEBOUNCE + 1);
    localparam int DW  = $clog2(SCAN_DIV);
    localparam int AW  = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int FW  = AW + 1;
    localparam int RW  = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int CLW = COLS > 1 ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {DWELL, EVAL, NEXT} state_t;

    state_t          state_q;
    logic [CLW-1:0]  col_q, col_d;
    logic [RW-1:0]   row_idx_q;
    logic [DW-1:0]   dwell_q;
    logic [ROWS-1:0] row_s1_q, row_s2_q, rows_q;
    logic [NK-1:0]   keys_q;
    logic [CW-1:0]   cnt_q [NK];
    logic [1:0]      ctrl_q;
    logic [4:0]      kidx;
    logic            raw, differ, hit, evt_push;
    logic [5:0]      evt;

    logic [5:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wp_q, rp_q;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            ovf_q, ovf_d, pop, do_push, nempty;
    logic [5:0]      head;
    logic [31:0]     rdata_d;
    logic            unused_wdata;

    assign unused_wdata = ^{i_wdata[31:9], i_wdata[7:2]};

    // hit is gated by scan_en so a key under evaluation when scanning stops never queues an event
    always_comb begin
        kidx   = 5'(int'(col_q) * ROWS + int'(row_idx_q));
        raw    = ~rows_q[row_idx_q];
        differ = raw != keys_q[kidx];
        hit    = ctrl_q[0] && state_q == EVAL && differ && cnt_q[kidx] == CW'(DEBOUNCE - 1);
`ifdef FP_BUTTON_RELEASE_EVT_EN
        evt_push = hit;
`else
        evt_push = hit && raw;
`endif
        evt    = {raw, kidx};
        col_d  = col_q == CLW'(COLS - 1) ? '0 : col_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q  <= '1;
            row_s2_q  <= '1;
            rows_q    <= '1;
            state_q   <= DWELL;
            col_q     <= '0;
            row_idx_q <= '0;
            dwell_q   <= '0;
            keys_q    <= '0;
            o_col     <= '1;
            for (int k = 0; k < NK; k++) cnt_q[k] <= '0;
        end else begin
            row_s1_q <= i_row;
            row_s2_q <= row_s1_q;
            if (!ctrl_q[0]) begin
                state_q   <= DWELL;
                col_q     <= '0;
                row_idx_q <= '0;
                dwell_q   <= '0;
                o_col     <= '1;
            end else begin
                o_col <= ~(COLS'(1) << col_q);
                case (state_q)
                    DWELL: begin
                        dwell_q <= dwell_q == DW'(SCAN_DIV - ROWS - 2) ? '0 : dwell_q + 1'b1;
                        if (dwell_q == DW'(SCAN_DIV - ROWS - 2)) begin
                            rows_q  <= row_s2_q;
                            state_q <= EVAL;
                        end
                    end
                    EVAL: begin
                        if (differ) begin
                            cnt_q[kidx] <= hit ? '0 : cnt_q[kidx] + 1'b1;
                            if (hit) keys_q[kidx] <= raw;
                        end else begin
                            cnt_q[kidx] <= '0;
                        end
                        row_idx_q <= row_idx_q == RW'(ROWS - 1) ? '0 : row_idx_q + 1'b1;
                        if (row_idx_q == RW'(ROWS - 1)) state_q <= NEXT;
                    end
                    default: begin
                        col_q   <= col_d;
                        o_col   <= ~(COLS'(1) << col_d);
                        state_q <= DWELL;
                    end
                endcase
            end
        end
    end

    // a push into a full FIFO is still accepted when the same cycle pops
    always_comb begin
        nempty  = fcnt_q != '0;
        pop     = i_rd && i_rreg == 2'd1 && nempty;
        do_push = evt_push && (fcnt_q != FW'(FIFO_DEPTH) || pop);
        fcnt_d  = fcnt_q + FW'(do_push) - FW'(pop);
        ovf_d   = (evt_push && !do_push) || (ovf_q && !(i_wr && i_wreg == 2'd0 && i_wdata[8]));
        head    = mem_q[rp_q];
        rdata_d = i_rreg == 2'd0 ? {22'd0, nempty, ovf_q, 8'(fcnt_q)}
                : i_rreg == 2'd1 ? (nempty ? {1'b1, 23'd0, head[5], 2'd0, head[4:0]} : 32'd0)
                : i_rreg == 2'd2 ? 32'(keys_q)
                : {30'd0, ctrl_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_rdata <= '0;
            ctrl_q  <= 2'b01;
            ovf_q   <= 1'b0;
            o_irq   <= 1'b0;
            wp_q    <= '0;
            rp_q    <= '0;
            fcnt_q  <= '0;
        end else begin
            if (i_rd) o_rdata <= rdata_d;
            if (do_push) begin
                mem_q[wp_q] <= evt;
                wp_q        <= wp_q + 1'b1;
            end
            if (pop) rp_q <= rp_q + 1'b1;
            if (i_wr && i_wreg == 2'd3) ctrl_q <= i_wdata[1:0];
            fcnt_q <= fcnt_d;
            ovf_q  <= ovf_d;
            o_irq  <= ctrl_q[1] && nempty;
        end
    end
endmodule
